// File: rtl/data_1r1w_byp_if.sv
// Port bundle for the 1R1W byte-lane data RAM: read/write request side plus
// the init_busy status seen by the load/store unit.
interface data_1r1w_byp_if #(
  parameter int DRWIDTH = 11,
  parameter int NLANE   = 4
);
  localparam int DW = 8 * NLANE;

  logic               init_busy;
  logic               ram_ren;
  logic [DRWIDTH-1:0] ram_radr;
  logic [DW-1:0]      ram_rdata;
  logic               ram_rvalid;
  logic [DRWIDTH-1:0] ram_wadr;
  logic [DW-1:0]      ram_wdata;
  logic [NLANE-1:0]   ram_wen;

  modport master (
    output ram_ren, ram_radr, ram_wadr, ram_wdata, ram_wen,
    input  init_busy, ram_rdata, ram_rvalid
  );

  modport slave (
    input  ram_ren, ram_radr, ram_wadr, ram_wdata, ram_wen,
    output init_busy, ram_rdata, ram_rvalid
  );
endinterface

// File: rtl/data_1r1w_byp.sv
// One-read/one-write byte-lane data RAM with optional write-first forwarding,
// 1- or 2-cycle read latency and a post-reset clear sequencer.
//
// state    | meaning
// ST_CLEAR | zeroing word clr_cnt each cycle; user reads/writes dropped
// ST_RUN   | normal service of read and lane-masked write requests
module data_1r1w_byp #(
  parameter int DRWIDTH    = 11,
  parameter int NLANE      = 4,
  parameter int RD_LAT     = 1,
  parameter int BYPASS     = 1,
  parameter int CLR_ON_RST = 1
) (
  input  logic            clk,
  input  logic            rst,
  data_1r1w_byp_if.slave  bus
);

  localparam int DW    = 8 * NLANE;
  localparam int DEPTH = 2 ** DRWIDTH;
  localparam logic [DRWIDTH:0] CLR_LAST = (DRWIDTH + 1)'(DEPTH - 1);
  localparam logic [DRWIDTH:0] CLR_ONE  = (DRWIDTH + 1)'(1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [DRWIDTH:0]   clr_cnt, clr_cnt_nxt;
  logic               init_busy;

  logic [DW-1:0]      mem [DEPTH];

  logic [NLANE-1:0]   wr_lane;
  logic [DRWIDTH-1:0] wr_adr;
  logic [DW-1:0]      wr_data;

  logic               rd_go;
  logic [DW-1:0]      rd_word;
  logic               s1_valid;
  logic [DW-1:0]      s1_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= (CLR_ON_RST != 0) ? ST_CLEAR : ST_RUN;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    init_busy   = 1'b0;
    case (state)
      ST_CLEAR: begin
        init_busy   = 1'b1;
        clr_cnt_nxt = clr_cnt + CLR_ONE;
        if (clr_cnt == CLR_LAST) begin
          state_nxt = ST_RUN;
        end
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
  end

  assign bus.init_busy = init_busy;

  // The clear sequencer owns the single write port while it runs.
  always_comb begin
    if (state == ST_CLEAR) begin
      wr_lane = '1;
      wr_adr  = clr_cnt[DRWIDTH-1:0];
      wr_data = '0;
    end else begin
      wr_lane = bus.ram_wen;
      wr_adr  = bus.ram_wadr;
      wr_data = bus.ram_wdata;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NLANE; i++) begin
      if (wr_lane[i]) begin
        mem[wr_adr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  assign rd_go = (state == ST_RUN) && bus.ram_ren;

  // Write-first forwarding is resolved per lane before the array value is captured.
  always_comb begin
    rd_word = mem[bus.ram_radr];
    if ((BYPASS != 0) && (bus.ram_radr == bus.ram_wadr)) begin
      for (int i = 0; i < NLANE; i++) begin
        if (bus.ram_wen[i]) begin
          rd_word[8*i +: 8] = bus.ram_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_go;
      if (rd_go) begin
        s1_data <= rd_word;
      end
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic          s2_valid;
      logic [DW-1:0] s2_data;

      always_ff @(posedge clk) begin
        if (rst) begin
          s2_valid <= 1'b0;
          s2_data  <= '0;
        end else begin
          s2_valid <= s1_valid;
          if (s1_valid) begin
            s2_data <= s1_data;
          end
        end
      end

      assign bus.ram_rvalid = s2_valid;
      assign bus.ram_rdata  = s2_data;
    end else begin : g_lat1
      assign bus.ram_rvalid = s1_valid;
      assign bus.ram_rdata  = s1_data;
    end
  endgenerate

endmodule

// File: doc/data_1r1w_byp.md
Name: data_1r1w_byp

Overview:
- Parametrised successor to the MA-stage byte-lane data RAM.
- One read port and one write port, with lane-granular write enables.
- Generalised in data width, lane count and depth; selectable read latency and read-during-write policy.
- Built-in clear sequencer zeroes the whole array after reset, so the load/store unit sees deterministic memory.

Parameters:
- DRWIDTH, 11: address width; depth = 2**DRWIDTH words.
- NLANE, 4: number of byte lanes; data width DW = 8*NLANE.
- RD_LAT, 1: read latency in cycles, legal values 1 or 2. Value 2 adds an output register.
- BYPASS, 1: 1 = write-first same-address forwarding per lane; 0 = read-first (old data).
- CLR_ON_RST, 1: 1 = zero the array after reset; 0 = skip the clear.

Ports:
- clk, input, 1: single clock; all logic is posedge.
- rst, input, 1: synchronous, active-high reset.
- init_busy, output, 1: high while the clear sequence runs.
- ram_ren, input, 1: read request.
- ram_radr, input, DRWIDTH: read word address.
- ram_rdata, output, DW: read data.
- ram_rvalid, output, 1: ram_rdata is valid this cycle.
- ram_wadr, input, DRWIDTH: write word address.
- ram_wdata, input, DW: write data; lane i = bits [8i+7:8i].
- ram_wen, input, NLANE: per-lane write enable.

Behaviour:
- Reset values while rst=1 at a clock edge:
  - ram_rdata=0, ram_rvalid=0, pipeline registers=0.
  - Clear counter=0.
  - State = CLEAR if CLR_ON_RST=1, else RUN.
  - init_busy=1 if CLR_ON_RST=1, else 0.
- Array contents are not affected by rst itself. Only the CLEAR state writes zeros.
- State machine, CLEAR -> RUN:
  - CLEAR, each cycle: write 0 to all lanes at clr_cnt, then clr_cnt += 1.
  - CLEAR lasts exactly 2**DRWIDTH cycles after rst deasserts.
  - On the cycle the word at clr_cnt = 2**DRWIDTH-1 is written, the next state is RUN and init_busy falls.
  - In CLEAR, ram_wen and ram_ren are ignored. No user write occurs, ram_rvalid stays 0, and requests are dropped, not queued.
  - Reset asserted mid-CLEAR restarts the clear from address 0.
  - RUN persists until rst.
- Write (RUN): at the posedge, lane i of word ram_wadr <= ram_wdata lane i when ram_wen[i]=1. Lanes with ram_wen[i]=0 are unchanged.
- Read, RD_LAT=1:
  - ram_ren=1 at edge N -> ram_rdata valid and ram_rvalid=1 after edge N.
  - ram_rvalid drops after the next edge with ram_ren=0.
- Read, RD_LAT=2: the same, one cycle later. The output stage registers data and valid.
- Back-to-back reads: one result per cycle, in order, no bubbles.
- ram_rdata holds its last value when no read completes. It is not re-zeroed.
- Same-cycle collision (ram_ren=1, ram_wen!=0, ram_radr==ram_wadr):
  - BYPASS=1: for each lane with ram_wen[i]=1, the returned lane is the new ram_wdata lane. Other lanes return the stored value.
  - BYPASS=0: all lanes return the pre-write stored value.
- Under RD_LAT=2, a write in the cycle after a read does not alter the already-captured read data.
- Addresses are full-range with no wrap logic. Address 2**DRWIDTH-1 is a normal word.
- The clear counter is DRWIDTH+1 bits wide, or equivalent terminal detect; there is no overflow into address 0.

Test Plan:
- Reset/clear, DRWIDTH=4, CLR_ON_RST=1:
  - Stimulus: rst 2 cycles, then release.
  - Required: init_busy=1 for exactly 16 cycles, then 0.
  - Required: ram_ren pulses during CLEAR produce ram_rvalid=0.
  - Required: afterwards, reads of all 16 addresses return 0x00000000.
- Lane writes, RD_LAT=1:
  - Stimulus: write 0xAABBCCDD wen=4'hF to addr 3; write 0x11223344 wen=4'b0101 to addr 3; read addr 3.
  - Required: rdata=0xAA22CC44 with rvalid one cycle after ren.
- Collision, BYPASS=1:
  - Stimulus: addr 5 holds 0x01020304; same cycle, ren=1 radr=5 and wen=4'b0011 wdata=0xFFFFEEEE wadr=5.
  - Required: rdata=0x0102EEEE.
  - Required: a following read of addr 5 returns 0x0102EEEE.
  - Required: with BYPASS=0 the collision read returns 0x01020304.
- RD_LAT=2 streaming:
  - Stimulus: ren held 4 cycles over addrs 0..3 preloaded with 0x10,0x11,0x12,0x13.
  - Required: rvalid high for 4 consecutive cycles starting 2 cycles after the first ren.
  - Required: data returns in order.
- Reset mid-clear:
  - Stimulus: assert rst after 7 CLEAR cycles.
  - Required: a fresh full 16-cycle busy window.
  - Required: a prior user-written nonzero word at addr 12 reads 0 afterwards.
- CLR_ON_RST=0:
  - Stimulus: release reset.
  - Required: init_busy=0 immediately.
  - Required: a write then read in the first cycles after reset complete normally.
